// File: rtl/spi_pkg.sv
// Shared definitions for the SPI mode-0 peripheral: byte width, fill byte and FSM state type.
package spi_pkg;
    localparam int SPI_BYTE_W = 8;
    localparam int SPI_CNT_W  = $clog2(SPI_BYTE_W);
    localparam logic [SPI_BYTE_W-1:0] SPI_FILL_BYTE = 8'h00;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_e;
endpackage

// File: rtl/spi_input_sync.sv
// Multi-flop synchronizer for one asynchronous pin, with single-cycle rise/fall pulses
// derived from the last stage and a registered copy of it.
module spi_input_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // NOTE: stages reset to the pin's idle level so leaving reset never looks like an edge.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
            r_prev <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_sync = r_sync[SYNC_STAGES-1];
    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;
    assign o_fall = ~r_sync[SYNC_STAGES-1] & r_prev;
endmodule

// File: rtl/spi_peripheral.sv
// SPI mode-0 peripheral: oversampled SCK/CS_n/MOSI, one-byte TX holding register, RX valid/ack.
// Optional sticky overrun flag and port are enabled with SPI_PERIPHERAL_OVERRUN_EN.
module spi_peripheral
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                  I_clk,
    input  logic                  I_reset_n,
    input  logic                  I_spi_clk,
    input  logic                  I_spi_cs_n,
    input  logic                  I_spi_mosi,
    output logic                  O_spi_miso,
    input  logic [SPI_BYTE_W-1:0] I_tx_data,
    input  logic                  I_tx_valid,
    output logic                  O_tx_ready,
    output logic [SPI_BYTE_W-1:0] O_rx_data,
    output logic                  O_rx_valid,
    input  logic                  I_rx_ack,
    output logic                  O_active
`ifdef SPI_PERIPHERAL_OVERRUN_EN
    ,
    output logic                  O_overrun
`endif
);
    logic w_sck_rise, w_sck_fall, w_cs_rise, w_cs_fall, w_mosi_s;

    spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .i_clk(I_clk), .i_reset_n(I_reset_n), .i_async(I_spi_clk),
        .o_sync(), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
    );
    spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .i_clk(I_clk), .i_reset_n(I_reset_n), .i_async(I_spi_cs_n),
        .o_sync(), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );
    spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .i_clk(I_clk), .i_reset_n(I_reset_n), .i_async(I_spi_mosi),
        .o_sync(w_mosi_s), .o_rise(), .o_fall()
    );

    spi_state_e            r_state;
    logic [SPI_CNT_W-1:0]  r_bitcnt;
    logic [SPI_BYTE_W-2:0] r_rx_shift;
    logic [SPI_BYTE_W-1:0] r_tx_shift, r_hold_data, r_rx_data;
    logic                  r_hold_full, r_boundary, r_rx_valid;

    logic                  w_sck_rise_act, w_sck_fall_act, w_byte_done, w_consume, w_write;
    logic [SPI_BYTE_W-1:0] w_load_byte;

    // CS deassertion takes priority over any SCK edge seen in the same cycle.
    assign w_sck_rise_act = (r_state == ACTIVE) && !w_cs_rise && w_sck_rise;
    assign w_sck_fall_act = (r_state == ACTIVE) && !w_cs_rise && w_sck_fall;
    assign w_byte_done    = w_sck_rise_act && (r_bitcnt == SPI_CNT_W'(SPI_BYTE_W - 1));
    assign w_consume      = ((r_state == IDLE) && w_cs_fall) || (w_sck_fall_act && r_boundary);
    assign w_write        = I_tx_valid && !r_hold_full;
    assign w_load_byte    = r_hold_full ? r_hold_data : SPI_FILL_BYTE;

    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            r_state    <= IDLE;
            r_bitcnt   <= '0;
            r_boundary <= 1'b0;
            r_rx_shift <= '0;
            r_tx_shift <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_cs_fall) begin
                    r_state    <= ACTIVE;
                    r_tx_shift <= w_load_byte;
                    r_bitcnt   <= '0;
                    r_boundary <= 1'b0;
                end
                ACTIVE: if (w_cs_rise) begin
                    r_state    <= IDLE;
                    r_bitcnt   <= '0;
                    r_boundary <= 1'b0;
                end else begin
                    if (w_sck_rise) begin
                        r_rx_shift <= {r_rx_shift[SPI_BYTE_W-3:0], w_mosi_s};
                        r_bitcnt   <= r_bitcnt + SPI_CNT_W'(1);
                        if (w_byte_done) r_boundary <= 1'b1;
                    end
                    if (w_sck_fall) begin
                        if (r_boundary) begin
                            r_tx_shift <= w_load_byte;
                            r_boundary <= 1'b0;
                        end else begin
                            r_tx_shift <= {r_tx_shift[SPI_BYTE_W-2:0], 1'b0};
                        end
                    end
                end
            endcase
        end
    end

    // A write that coincides with a consume of an empty register survives the consume.
    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            r_hold_full <= 1'b0;
            r_hold_data <= '0;
        end else begin
            if (w_consume) r_hold_full <= 1'b0;
            if (w_write) begin
                r_hold_full <= 1'b1;
                r_hold_data <= I_tx_data;
            end
        end
    end

    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
        end else if (w_byte_done) begin
            r_rx_data  <= {r_rx_shift, w_mosi_s};
            r_rx_valid <= 1'b1;
        end else if (I_rx_ack) begin
            r_rx_valid <= 1'b0;
        end
    end

`ifdef SPI_PERIPHERAL_OVERRUN_EN
    logic r_overrun;

    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n)                                   r_overrun <= 1'b0;
        else if (w_byte_done && r_rx_valid && !I_rx_ack)  r_overrun <= 1'b1;
        else if (I_rx_ack)                                r_overrun <= 1'b0;
    end

    assign O_overrun = r_overrun;
`else
    // Without the overrun flag an unread byte is silently overwritten.
`endif

    assign O_spi_miso = (r_state == ACTIVE) && r_tx_shift[SPI_BYTE_W-1];
    assign O_active   = (r_state == ACTIVE);
    assign O_tx_ready = !r_hold_full;
    assign O_rx_data  = r_rx_data;
    assign O_rx_valid = r_rx_valid;
endmodule

// File: doc/spi_peripheral.md
# spi_peripheral

SPI mode-0 peripheral (slave) that answers the on-chip `spicontroller` master or any external mode-0 master. It uses MSB-first, 8-bit frames with no fixed frame limit per chip-select assertion. SCK, CS_n and MOSI are oversampled in the `I_clk` domain, and MISO is driven from a one-byte transmit holding register. Received bytes go to the core through a valid/ack handshake.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth for SCK/CS_n/MOSI; minimum 2.
- `I_clk`  in  1  system clock; all state on rising edge.
- `I_reset_n`  in  1  asynchronous, active-low reset.
- `I_spi_clk`  in  1  SCK from master, idle low.
- `I_spi_cs_n`  in  1  chip select, active low.
- `I_spi_mosi`  in  1  serial data from master.
- `O_spi_miso`  out  1  serial data to master.
- `I_tx_data`  in  8  byte to send next.
- `I_tx_valid`  in  1  write strobe for the holding register.
- `O_tx_ready`  out  1  holding register empty.
- `O_rx_data`  out  8  last complete received byte.
- `O_rx_valid`  out  1  `O_rx_data` unread.
- `I_rx_ack`  in  1  core consumed `O_rx_data`.
- `O_active`  out  1  synchronized CS asserted.
- `O_overrun`  out  1  present only with `SPI_PERIPHERAL_OVERRUN_EN`.

## Operation
- Synchronizers: SCK and CS_n pass through `SYNC_STAGES` flops each; MOSI likewise. Synchronizer reset values: SCK 0, CS_n 1, MOSI 0. Edges are detected by comparing the last sync stage with a registered copy.
- States:
  - IDLE → ACTIVE on a synced CS falling edge.
  - ACTIVE → IDLE on a synced CS rising edge, from any bit position.
- On entry to ACTIVE:
  - `tx_shift` ← holding register if it is full, else fill byte 8'h00.
  - Holding register marked empty.
  - `bitcnt` ← 0.
- ACTIVE, synced SCK rising: `rx_shift` ← {rx_shift[6:0], mosi_s}; `bitcnt`+1. When `bitcnt`==7:
  - `O_rx_data` ← {rx_shift[6:0], mosi_s}.
  - `O_rx_valid` ← 1.
  - `bitcnt` ← 0 and the byte-boundary flag is set.
- ACTIVE, synced SCK falling:
  - Byte-boundary flag set: reload `tx_shift` from the holding register (or 8'h00 if empty), mark holding empty, clear the flag.
  - Otherwise: `tx_shift` ← {tx_shift[6:0], 0}.
- `O_spi_miso` = `tx_shift[7]` in ACTIVE, 0 in IDLE. There is no tristate; the top level gates MISO with CS.
- Holding register:
  - Write occurs when `I_tx_valid` && `O_tx_ready`; `O_tx_ready` then drops.
  - `I_tx_valid` while not ready is ignored.
  - Write while empty in the same cycle as a consume: the consumer takes 8'h00 and the write lands.
- RX handshake:
  - `O_rx_valid` holds until `I_rx_ack`.
  - Ack in the same cycle as a new byte: the new byte wins and valid stays 1.
  - New byte while valid and not acked: data is overwritten.
- CS rising mid-byte: partial byte discarded, no `O_rx_valid`, holding register untouched, `bitcnt` reset.
- `O_active` = 1 in ACTIVE.

## Timing
- Reset values: `O_spi_miso` 0, `O_rx_data` 8'h00, `O_rx_valid` 0, `O_tx_ready` 1, `O_active` 0, `O_overrun` 0; holding register empty, state IDLE.
- Pin-to-action latency: a pin change is acted on at the (`SYNC_STAGES`+1)th `I_clk` edge after it is first sampled. This applies to `O_rx_valid` after the 8th SCK rise, to the MISO update after an SCK fall, and to `O_active`.
- Master requirements:
  - SCK high and low phases each ≥ `SYNC_STAGES`+2 `I_clk` cycles.
  - CS fall to first SCK rise ≥ `SYNC_STAGES`+2 cycles.
  - Last SCK fall to CS rise ≥ `SYNC_STAGES`+2 cycles.
- Core handshakes (`I_tx_valid`, `I_rx_ack`) are single-cycle and synchronous; `O_tx_ready` and `O_rx_valid` update the cycle after the causing event.

## Configuration
- `SPI_PERIPHERAL_OVERRUN_EN` defined:
  - `O_overrun` port exists.
  - Set sticky when a new byte completes while `O_rx_valid`=1 and `I_rx_ack`=0.
  - Cleared by `I_rx_ack` unless set again in the same cycle.
- Undefined: no port, no flag logic; overwrite is silent.

## Structure
- Package `spi_pkg`:
  - `SPI_BYTE_W` = 8.
  - `SPI_FILL_BYTE` = 8'h00.
  - Peripheral state enum {IDLE, ACTIVE}.
- Sub-module `spi_input_sync`: parameterised `SYNC_STAGES` synchronizer with rise/fall pulse outputs, instantiated for SCK and CS_n. MOSI uses the same instance type without edge outputs.

## Test plan
- Reset asserted mid-operation → all outputs take their reset values immediately, with no `I_clk` edge needed. After release, `O_tx_ready`=1.
- Preload 8'hA5, CS low, master sends 8'h3C (SCK half-period 4 cycles, `SYNC_STAGES`=2) → MISO samples 1,0,1,0,0,1,0,1; `O_rx_data`=8'h3C, `O_rx_valid`=1 held until ack; `O_tx_ready`=1 after CS fall.
- One CS, two bytes 8'h11, 8'h22, no second preload and no ack → second MISO byte 8'h00; `O_rx_data`=8'h22; `O_overrun`=1 with the macro, port absent without it.
- CS raised after 5 SCK rises → no `O_rx_valid`, `O_active`=0. A following full byte 8'h81 is received correctly.
- `I_rx_ack` in the exact cycle a new byte 8'h5A completes → `O_rx_valid` stays 1, `O_rx_data`=8'h5A, `O_overrun`=0.
- `I_tx_valid` with 8'h77 while holding full with 8'h12 → ignored; the next frame transmits 8'h12.
